// File: rtl/pio_pkg.sv
// Shared definitions for the bidirectional Avalon-MM PIO: register map and edge-type encodings.
package pio_pkg;

  // Register map (3-bit word address)
  localparam logic [2:0] PIO_ADDR_DATA    = 3'd0;
  localparam logic [2:0] PIO_ADDR_DIR     = 3'd1;
  localparam logic [2:0] PIO_ADDR_IRQMASK = 3'd2;
  localparam logic [2:0] PIO_ADDR_EDGECAP = 3'd3;
  localparam logic [2:0] PIO_ADDR_SET     = 3'd4;
  localparam logic [2:0] PIO_ADDR_CLR     = 3'd5;

  // Which input transitions are captured
  typedef enum logic [1:0] {
    EDGE_ANY  = 2'd0,
    EDGE_RISE = 2'd1,
    EDGE_FALL = 2'd2
  } edge_type_e;

endpackage

// File: rtl/pio_edge_sync.sv
// Per-bit input synchroniser, one-cycle history (pin_prev), edge selection and
// post-reset warm-up gate. Produces the synchronised pin value and the edge_hit vector.
module pio_edge_sync
  import pio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int EDGE_TYPE   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] pin_in,
  output logic [WIDTH-1:0] pin_sync,
  output logic [WIDTH-1:0] edge_hit
);

  localparam int                WARM_W    = $clog2(SYNC_STAGES + 2);
  localparam logic [WARM_W-1:0] WARM_INIT = WARM_W'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  prev_q;
  logic [WARM_W-1:0]                 warm_q;
  logic [WARM_W-1:0]                 warm_d;
  logic [WIDTH-1:0]                  rise;
  logic [WIDTH-1:0]                  fall;
  logic [WIDTH-1:0]                  sel;

  assign pin_sync = sync_q[SYNC_STAGES-1];

  // Synchroniser chain and one-cycle-delayed copy of its output
  // NOTE: clocked state always uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= '0;
      warm_q <= WARM_INIT;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin_in};
      prev_q <= pin_sync;
      warm_q <= warm_d;
    end
  end

  // Warm-up countdown, then edge selection gated until the chain has filled
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    warm_d   = warm_q;
    rise     = pin_sync & ~prev_q;
    fall     = ~pin_sync & prev_q;
    sel      = rise | fall;
    edge_hit = '0;
    if (warm_q != '0) begin
      warm_d = warm_q - WARM_W'(1);
    end
    case (edge_type_e'(EDGE_TYPE))
      EDGE_RISE: sel = rise;
      EDGE_FALL: sel = fall;
      EDGE_ANY:  sel = rise | fall;
      default:   sel = rise | fall;
    endcase
    if (warm_q == '0) begin
      edge_hit = sel;
    end
  end

endmodule

// File: rtl/avalon_pio_bidir.sv
// Avalon-MM bidirectional PIO slave: output data, per-bit direction, synchronised
// readback, edge capture and maskable level interrupt.
// Optional build macro PIO_BITSET_EN adds atomic SET (addr 4) / CLR (addr 5) of the data register.
module avalon_pio_bidir
  import pio_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] OUT_RESET   = '0,
  parameter logic [WIDTH-1:0] DIR_RESET   = '0,
  parameter int               EDGE_TYPE   = 0,
  parameter int               SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [WIDTH-1:0] writedata,
  output logic [WIDTH-1:0] readdata,
  output logic             irq,
  input  logic [WIDTH-1:0] pin_in,
  output logic [WIDTH-1:0] pin_out,
  output logic [WIDTH-1:0] pin_oe
);

  logic             wr_en;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
  logic [WIDTH-1:0] cap_clr;
  logic [WIDTH-1:0] pin_sync;
  logic [WIDTH-1:0] edge_hit;

  pio_edge_sync #(
    .WIDTH      (WIDTH),
    .EDGE_TYPE  (EDGE_TYPE),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .pin_in  (pin_in),
    .pin_sync(pin_sync),
    .edge_hit(edge_hit)
  );

  assign wr_en   = chipselect & ~write_n;
  assign pin_out = data_out_q;
  assign pin_oe  = dir_q;
  assign irq     = |(edge_cap_q & mask_q);

  // Register write decode; a new edge overrides a same-cycle clear of that bit
  always_comb begin
    data_out_d = data_out_q;
    dir_d      = dir_q;
    mask_d     = mask_q;
    cap_clr    = '0;
    if (wr_en) begin
      case (address)
        PIO_ADDR_DATA:    data_out_d = writedata;
        PIO_ADDR_DIR:     dir_d      = writedata;
        PIO_ADDR_IRQMASK: mask_d     = writedata;
        PIO_ADDR_EDGECAP: cap_clr    = writedata;
`ifdef PIO_BITSET_EN
        PIO_ADDR_SET:     data_out_d = data_out_q | writedata;
        PIO_ADDR_CLR:     data_out_d = data_out_q & ~writedata;
`endif
        default: ;
      endcase
    end
    edge_cap_d = (edge_cap_q & ~cap_clr) | edge_hit;
  end

  // Register file state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out_q <= OUT_RESET;
      dir_q      <= DIR_RESET;
      mask_q     <= '0;
      edge_cap_q <= '0;
    end else begin
      data_out_q <= data_out_d;
      dir_q      <= dir_d;
      mask_q     <= mask_d;
      edge_cap_q <= edge_cap_d;
    end
  end

  // Zero-wait-state read mux
  always_comb begin
    readdata = '0;
    case (address)
      PIO_ADDR_DATA:    readdata = pin_sync;
      PIO_ADDR_DIR:     readdata = dir_q;
      PIO_ADDR_IRQMASK: readdata = mask_q;
      PIO_ADDR_EDGECAP: readdata = edge_cap_q;
      PIO_ADDR_SET,
      PIO_ADDR_CLR:     readdata = '0;
      default:          readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_avalon_pio_bidir.sv
// Self-checking bench for avalon_pio_bidir (WIDTH=8, OUT_RESET=A5, DIR_RESET=0F,
// rising-edge capture, two synchroniser stages). Honours PIO_BITSET_EN if defined.
module tb_avalon_pio_bidir;

  localparam int         W   = 8;
  localparam int         S   = 2;
  localparam logic [7:0] OUTR = 8'hA5;
  localparam logic [7:0] DIRR = 8'h0F;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [2:0] address = 3'd0;
  logic       chipselect = 1'b0;
  logic       write_n = 1'b1;
  logic [7:0] writedata = 8'h00;
  logic [7:0] readdata;
  logic       irq;
  logic [7:0] pin_in = 8'hFF;
  logic [7:0] pin_out;
  logic [7:0] pin_oe;

  int chk = 0;
  int err = 0;

  // Reference model state
  logic [7:0] hist[$];   // hist[k] = pin_in sampled at the k-th clock edge after reset release
  int         n;         // edges since reset release
  logic [7:0] m_data, m_dir, m_mask, m_cap;

  avalon_pio_bidir #(
    .WIDTH      (W),
    .OUT_RESET  (OUTR),
    .DIR_RESET  (DIRR),
    .EDGE_TYPE  (1),
    .SYNC_STAGES(S)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .irq       (irq),
    .pin_in    (pin_in),
    .pin_out   (pin_out),
    .pin_oe    (pin_oe)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic model_reset();
    hist.delete();
    hist.push_back(8'h00);
    n      = 0;
    m_data = OUTR;
    m_dir  = DIRR;
    m_mask = 8'h00;
    m_cap  = 8'h00;
  endtask

  // One clock: the model applies the rules at the edge, then returns on the falling edge.
  // A transition between samples k-1 and k (k >= 2) is captured S edges after sample k.
  task automatic tick();
    logic [7:0] hit, clr;
    @(posedge clk);
    if (reset_n) begin
      n++;
      hist.push_back(pin_in);
      hit = 8'h00;
      clr = 8'h00;
      if (n - S >= 2) hit = hist[n-S] & ~hist[n-S-1];
      if (chipselect && !write_n) begin
        case (address)
          3'd0: m_data = writedata;
          3'd1: m_dir  = writedata;
          3'd2: m_mask = writedata;
          3'd3: clr    = writedata;
`ifdef PIO_BITSET_EN
          3'd4: m_data = m_data | writedata;
          3'd5: m_data = m_data & ~writedata;
`endif
          default: ;
        endcase
      end
      m_cap = (m_cap & ~clr) | hit;
    end
    @(negedge clk);
  endtask

  function automatic logic [7:0] exp_read(input logic [2:0] a);
    case (a)
      3'd0:    return (n >= S) ? hist[n-S+1] : 8'h00;
      3'd1:    return m_dir;
      3'd2:    return m_mask;
      3'd3:    return m_cap;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic exp_irq();
    return |(m_cap & m_mask);
  endfunction

  task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic set_addr(input logic [2:0] a);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    pin_in  = 8'hFF;
    repeat (3) @(negedge clk);
    chk++; if (pin_out !== OUTR) begin err++; $display("FAIL reset_pin_out got %h want %h", pin_out, OUTR); end
    chk++; if (pin_oe !== DIRR) begin err++; $display("FAIL reset_pin_oe got %h want %h", pin_oe, DIRR); end
    chk++; if (irq !== 1'b0) begin err++; $display("FAIL reset_irq got %b want 0", irq); end
    reset_n = 1'b1;
    model_reset();
    repeat (8) tick();
    set_addr(3'd3);
    chk++; if (readdata !== 8'h00) begin err++; $display("FAIL reset_edgecap got %h want 00", readdata); end
    set_addr(3'd0);
    chk++; if (readdata !== 8'hFF) begin err++; $display("FAIL reset_data_read got %h want ff", readdata); end
    set_addr(3'd2);
    chk++; if (readdata !== 8'h00) begin err++; $display("FAIL reset_mask got %h want 00", readdata); end
  endtask

  task automatic test_loopback();
    bus_write(3'd1, 8'hFF);
    bus_write(3'd0, 8'h3C);
    chk++; if (pin_out !== 8'h3C) begin err++; $display("FAIL loop_pin_out got %h want 3c", pin_out); end
    chk++; if (pin_oe !== 8'hFF) begin err++; $display("FAIL loop_pin_oe got %h want ff", pin_oe); end
    pin_in = pin_out;
    for (int i = 1; i <= S; i++) begin
      tick();
      set_addr(3'd0);
      chk++; if (readdata !== exp_read(3'd0)) begin err++; $display("FAIL loop_read_%0d got %h want %h", i, readdata, exp_read(3'd0)); end
      if (i < S) begin
        chk++; if (readdata === 8'h3C) begin err++; $display("FAIL loop_early got %h want not 3c", readdata); end
      end
    end
    chk++; if (readdata !== 8'h3C) begin err++; $display("FAIL loop_final got %h want 3c", readdata); end
  endtask

  task automatic test_edge_rise();
    pin_in = 8'h00;
    repeat (5) tick();
    bus_write(3'd3, 8'hFF);
    set_addr(3'd3);
    chk++; if (readdata !== 8'h00) begin err++; $display("FAIL rise_cleared got %h want 00", readdata); end
    pin_in = 8'h04;
    for (int i = 1; i <= S + 1; i++) begin
      tick();
      set_addr(3'd3);
      chk++; if (readdata !== ((i <= S) ? 8'h00 : 8'h04)) begin
        err++; $display("FAIL rise_latency_%0d got %h want %h", i, readdata, (i <= S) ? 8'h00 : 8'h04);
      end
    end
    pin_in = 8'h00;
    repeat (5) tick();
    set_addr(3'd3);
    chk++; if (readdata !== 8'h04) begin err++; $display("FAIL fall_ignored got %h want 04", readdata); end
  endtask

  task automatic test_irq();
    bus_write(3'd2, 8'h04);
    chk++; if (irq !== 1'b1) begin err++; $display("FAIL irq_set got %b want 1", irq); end
    bus_write(3'd3, 8'h04);
    chk++; if (irq !== 1'b0) begin err++; $display("FAIL irq_clear got %b want 0", irq); end
    pin_in = 8'h04;
    repeat (S) tick();
    set_addr(3'd3);
    chk++; if (readdata !== 8'h00) begin err++; $display("FAIL irq_pre_edge got %h want 00", readdata); end
    bus_write(3'd3, 8'h04);
    set_addr(3'd3);
    chk++; if (readdata !== 8'h04) begin err++; $display("FAIL set_wins got %h want 04", readdata); end
    chk++; if (irq !== 1'b1) begin err++; $display("FAIL set_wins_irq got %b want 1", irq); end
    pin_in = 8'h00;
    repeat (4) tick();
  endtask

  task automatic test_bitset();
    bus_write(3'd0, 8'h00);
    bus_write(3'd4, 8'h81);
`ifdef PIO_BITSET_EN
    chk++; if (pin_out !== 8'h81) begin err++; $display("FAIL set_pin_out got %h want 81", pin_out); end
`else
    chk++; if (pin_out !== 8'h00) begin err++; $display("FAIL set_pin_out got %h want 00", pin_out); end
`endif
    bus_write(3'd5, 8'h01);
`ifdef PIO_BITSET_EN
    chk++; if (pin_out !== 8'h80) begin err++; $display("FAIL clr_pin_out got %h want 80", pin_out); end
`else
    chk++; if (pin_out !== 8'h00) begin err++; $display("FAIL clr_pin_out got %h want 00", pin_out); end
`endif
    set_addr(3'd4);
    chk++; if (readdata !== 8'h00) begin err++; $display("FAIL set_reads_zero got %h want 00", readdata); end
    bus_write(3'd7, 8'hFF);
    chk++; if (pin_out !== m_data) begin err++; $display("FAIL addr7_ignored got %h want %h", pin_out, m_data); end
  endtask

  task automatic test_random(input int cycles);
    logic [2:0] ra;
    for (int i = 0; i < cycles; i++) begin
      pin_in     = 8'($urandom);
      address    = 3'($urandom_range(0, 7));
      writedata  = 8'($urandom);
      chipselect = ($urandom_range(0, 3) != 0);
      write_n    = ($urandom_range(0, 2) != 0);
      tick();
      chk++; if (pin_out !== m_data) begin err++; $display("FAIL rand_pin_out cyc %0d got %h want %h", i, pin_out, m_data); end
      chk++; if (pin_oe !== m_dir) begin err++; $display("FAIL rand_pin_oe cyc %0d got %h want %h", i, pin_oe, m_dir); end
      chk++; if (irq !== exp_irq()) begin err++; $display("FAIL rand_irq cyc %0d got %b want %b", i, irq, exp_irq()); end
      ra = 3'($urandom_range(0, 7));
      set_addr(ra);
      chk++; if (readdata !== exp_read(ra)) begin err++; $display("FAIL rand_read a%0d cyc %0d got %h want %h", ra, i, readdata, exp_read(ra)); end
    end
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic test_reset_mid();
    bus_write(3'd2, 8'hFF);
    test_random(30);
    // Assert reset away from any clock edge
    #2;
    reset_n = 1'b0;
    #1;
    chk++; if (pin_out !== OUTR) begin err++; $display("FAIL mid_pin_out got %h want %h", pin_out, OUTR); end
    chk++; if (pin_oe !== DIRR) begin err++; $display("FAIL mid_pin_oe got %h want %h", pin_oe, DIRR); end
    chk++; if (irq !== 1'b0) begin err++; $display("FAIL mid_irq got %b want 0", irq); end
    address = 3'd3; #1;
    chk++; if (readdata !== 8'h00) begin err++; $display("FAIL mid_edgecap got %h want 00", readdata); end
    address = 3'd2; #1;
    chk++; if (readdata !== 8'h00) begin err++; $display("FAIL mid_mask got %h want 00", readdata); end
    address = 3'd0; #1;
    chk++; if (readdata !== 8'h00) begin err++; $display("FAIL mid_sync got %h want 00", readdata); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      pin_in = 8'($urandom);
    end
    @(negedge clk);
    pin_in  = 8'hFF;
    reset_n = 1'b1;
    model_reset();
    for (int i = 1; i <= S + 3; i++) begin
      tick();
      set_addr(3'd3);
      chk++; if (readdata !== 8'h00) begin err++; $display("FAIL warmup_%0d got %h want 00", i, readdata); end
    end
    test_random(60);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_loopback();
    test_edge_rise();
    test_irq();
    test_bitset();
    test_random(400);
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end

endmodule
